// File: rtl/regwrite_trace_buffer_pkg.sv
// Shared definitions for the register-write trace buffer:
// FSM state encoding and the trace entry width helper.
package regwrite_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_ARMED   = 2'd1;
    localparam logic [1:0] STATE_CAPTURE = 2'd2;
    localparam logic [1:0] STATE_DONE    = 2'd3;

    // Entry layout, MSB->LSB: {cycle, pc, waddr, wdata}
    function automatic int entry_w(
        input int cyc_w,
        input int pc_w,
        input int ra_w,
        input int d_w
    );
        return cyc_w + pc_w + ra_w + d_w;
    endfunction

endpackage

// File: rtl/regwrite_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W, one synchronous write port,
// asynchronous read port, no reset.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module regwrite_trace_buffer_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 85
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Register-file write snooper: captures {cycle, pc, waddr, wdata}
// of every non-r0 write into a circular trace after arm (optionally
// gated by a PC match), then drains entries via rd_valid/rd_ready.
// Ports: clk, reset, arm, stop, trig_en, trig_pc, pc, reg_we,
// reg_waddr, reg_wdata, rd_ready in; rd_valid, rd_data, state,
// count, overflow out.
module regwrite_trace_buffer
    import regwrite_trace_buffer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int DEPTH      = 16,
    parameter int CYC_W      = 16,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  trig_en,
    input  logic [PC_W-1:0]       trig_pc,
    input  logic [PC_W-1:0]       pc,
    input  logic                  reg_we,
    input  logic [REG_ADDR_W-1:0] reg_waddr,
    input  logic [DATA_W-1:0]     reg_wdata,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [entry_w(CYC_W, PC_W, REG_ADDR_W, DATA_W)-1:0] rd_data,
    output logic [1:0]            state,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_w(CYC_W, PC_W, REG_ADDR_W, DATA_W);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_n;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   w_wr_ptr_n;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_ptr_n;
    logic            r_overflow;
    logic            w_overflow_n;
    logic [CYC_W-1:0] r_cycle;

    logic            w_cap;
    logic            w_hit;
    logic            w_we;
    logic            w_rd_valid;
    logic            w_pop;
    logic [EW-1:0]   w_wentry;
    logic [EW-1:0]   w_rentry;

    assign w_cap      = reg_we && (reg_waddr != '0);
    assign w_hit      = (pc == trig_pc);
    assign w_rd_valid = (r_state == ST_DONE) && (r_count != '0);
    assign w_pop      = w_rd_valid && rd_ready;
    assign w_wentry   = {r_cycle, pc, reg_waddr, reg_wdata};

    always_comb begin
        w_state_n    = r_state;
        w_count_n    = r_count;
        w_wr_ptr_n   = r_wr_ptr;
        w_rd_ptr_n   = r_rd_ptr;
        w_overflow_n = r_overflow;
        w_we         = 1'b0;

        if (arm) begin
            w_state_n    = trig_en ? ST_ARMED : ST_CAPTURE;
            w_count_n    = '0;
            w_wr_ptr_n   = '0;
            w_rd_ptr_n   = '0;
            w_overflow_n = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (stop) begin
                        w_state_n = ST_DONE;
                    end else if (w_hit) begin
                        w_state_n = ST_CAPTURE;
                        // Match-cycle write becomes entry 0
                        if (w_cap) begin
                            w_we       = 1'b1;
                            w_wr_ptr_n = r_wr_ptr + AW'(1);
                            w_count_n  = r_count + CW'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_cap && (r_count != FULL)) begin
                        w_we       = 1'b1;
                        w_wr_ptr_n = r_wr_ptr + AW'(1);
                        w_count_n  = r_count + CW'(1);
                        if ((WRAP == 0) &&
                            (r_count == FULL - CW'(1))) begin
                            w_state_n = ST_DONE;
                        end
                    end else if (w_cap && (WRAP != 0)) begin
                        // Full ring: drop the oldest entry
                        w_we         = 1'b1;
                        w_wr_ptr_n   = r_wr_ptr + AW'(1);
                        w_rd_ptr_n   = r_rd_ptr + AW'(1);
                        w_overflow_n = 1'b1;
                    end
                    if (stop) begin
                        w_state_n = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_pop) begin
                        w_rd_ptr_n = r_rd_ptr + AW'(1);
                        w_count_n  = r_count - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_count    <= w_count_n;
            r_wr_ptr   <= w_wr_ptr_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_overflow <= w_overflow_n;
            r_cycle    <= r_cycle + CYC_W'(1);
        end
    end

    regwrite_trace_buffer_trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_we & ~reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rentry)
    );

    assign rd_valid = w_rd_valid;
    assign rd_data  = w_rd_valid ? w_rentry : '0;
    assign state    = r_state;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Bench for regwrite_trace_buffer: two DEPTH=4 instances sharing
// stimulus, one stop-when-full (WRAP=0), one overwrite (WRAP=1).
module tb_regwrite_trace_buffer;

    localparam int EW = 16 + 32 + 5 + 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        stop;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        rd_ready;

    logic          vld0, vld1;
    logic [EW-1:0] dat0, dat1;
    logic [1:0]    st0, st1;
    logic [2:0]    cnt0, cnt1;
    logic          ovf0, ovf1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] tb_cyc = '0;

    always #5 clk = ~clk;

    regwrite_trace_buffer #(
        .DEPTH (4),
        .WRAP  (0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .stop      (stop),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .pc        (pc),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .rd_ready  (rd_ready),
        .rd_valid  (vld0),
        .rd_data   (dat0),
        .state     (st0),
        .count     (cnt0),
        .overflow  (ovf0)
    );

    regwrite_trace_buffer #(
        .DEPTH (4),
        .WRAP  (1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .stop      (stop),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .pc        (pc),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .rd_ready  (rd_ready),
        .rd_valid  (vld1),
        .rd_data   (dat1),
        .state     (st1),
        .count     (cnt1),
        .overflow  (ovf1)
    );

    typedef struct {
        logic          arm;
        logic          stop;
        logic          rdy;
        logic          we;
        logic [4:0]    wa;
        logic [31:0]   wd;
        logic [31:0]   pcv;
        logic [1:0]    st;
        logic [2:0]    cnt;
        logic          vld;
        logic [EW-1:0] dat;
    } vec_t;

    vec_t tv [8];

    function automatic logic [EW-1:0] mk(
        input logic [15:0] c,
        input logic [31:0] p,
        input logic [4:0]  a,
        input logic [31:0] d
    );
        return {c, p, a, d};
    endfunction

    function automatic vec_t row(
        input logic          a,
        input logic          s,
        input logic          r,
        input logic          w,
        input logic [4:0]    wa,
        input logic [31:0]   wd,
        input logic [31:0]   p,
        input logic [1:0]    st,
        input logic [2:0]    cnt,
        input logic          vld,
        input logic [EW-1:0] dat
    );
        vec_t v;
        v.arm = a;   v.stop = s; v.rdy = r; v.we = w;
        v.wa  = wa;  v.wd = wd;  v.pcv = p;
        v.st  = st;  v.cnt = cnt; v.vld = vld; v.dat = dat;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        tb_cyc = reset ? 16'd0 : tb_cyc + 16'd1;
        #1;
    endtask

    task automatic chk(
        input string        nm,
        input logic [127:0] act,
        input logic [127:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        arm = 0; stop = 0; reg_we = 0; reg_waddr = '0;
        reg_wdata = '0; rd_ready = 0;
    endtask

    logic [15:0] stamp [1:6];
    logic [15:0] sa;

    initial begin
        reset = 1; trig_en = 0; trig_pc = '0; pc = '0;
        idle_in();
        tick();
        tick();
        reset = 0;

        chk("rst_state0", st0, 2'd0);
        chk("rst_count0", cnt0, 3'd0);
        chk("rst_valid0", vld0, 1'b0);
        chk("rst_data0", dat0, '0);
        chk("rst_ovf1", ovf1, 1'b0);

        // Test 1: immediate capture with r0 filter
        tv[0] = row(1,0,0,0,5'd0,32'h0,32'h0,   2,0,0,'0);
        tv[1] = row(0,0,0,1,5'd8,32'h5,32'h100, 2,1,0,'0);
        tv[2] = row(0,0,0,1,5'd9,32'hA,32'h104, 2,2,0,'0);
        tv[3] = row(0,0,0,1,5'd0,32'hFF,32'h108,2,2,0,'0);
        tv[4] = row(0,1,0,0,5'd0,32'h0,32'h10C, 3,2,1,
                    mk(16'd1,32'h100,5'd8,32'h5));
        tv[5] = row(0,0,1,0,5'd0,32'h0,32'h110, 3,1,1,
                    mk(16'd2,32'h104,5'd9,32'hA));
        tv[6] = row(0,0,1,0,5'd0,32'h0,32'h114, 3,0,0,'0);
        tv[7] = row(0,0,1,0,5'd0,32'h0,32'h118, 3,0,0,'0);

        for (int i = 0; i < 8; i++) begin
            arm = tv[i].arm; stop = tv[i].stop;
            rd_ready = tv[i].rdy; reg_we = tv[i].we;
            reg_waddr = tv[i].wa; reg_wdata = tv[i].wd;
            pc = tv[i].pcv;
            tick();
            chk($sformatf("t1_st0[%0d]", i), st0, tv[i].st);
            chk($sformatf("t1_cnt0[%0d]", i), cnt0, tv[i].cnt);
            chk($sformatf("t1_vld0[%0d]", i), vld0, tv[i].vld);
            chk($sformatf("t1_dat0[%0d]", i), dat0, tv[i].dat);
            chk($sformatf("t1_dat1[%0d]", i), dat1, tv[i].dat);
            chk($sformatf("t1_cnt1[%0d]", i), cnt1, tv[i].cnt);
        end
        idle_in();

        // Test 2: PC trigger
        trig_en = 1; trig_pc = 32'h10; pc = 32'h0;
        arm = 1; tick(); arm = 0;
        chk("t2_armed", st0, 2'd1);
        reg_we = 1; reg_waddr = 5'd3; reg_wdata = 32'h11;
        tick();
        pc = 32'h4; reg_waddr = 5'd4; reg_wdata = 32'h22;
        tick();
        chk("t2_still_armed", st0, 2'd1);
        chk("t2_no_entries", cnt0, 3'd0);
        pc = 32'h10; reg_waddr = 5'd2; reg_wdata = 32'h7;
        sa = tb_cyc;
        tick();
        chk("t2_capture", st0, 2'd2);
        chk("t2_count", cnt0, 3'd1);
        reg_we = 0; pc = 32'h14; stop = 1;
        tick();
        stop = 0;
        chk("t2_done", st0, 2'd3);
        chk("t2_entry0", dat0, mk(sa, 32'h10, 5'd2, 32'h7));
        rd_ready = 1; tick(); rd_ready = 0;
        chk("t2_drained", vld0, 1'b0);
        trig_en = 0; trig_pc = '0;

        // Tests 3 & 4: six writes, stop-when-full vs wrap
        arm = 1; tick(); arm = 0;
        chk("t3_cap0", st0, 2'd2);
        chk("t4_ovf_clear", ovf1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            reg_we = 1; reg_waddr = 5'(k); reg_wdata = 32'(k);
            pc = 32'h200 + 32'(4 * k);
            stamp[k] = tb_cyc;
            tick();
            if (k == 4) begin
                chk("t3_full_done", st0, 2'd3);
                chk("t3_full_cnt", cnt0, 3'd4);
                chk("t4_full_cap", st1, 2'd2);
                chk("t4_no_ovf_yet", ovf1, 1'b0);
            end
        end
        reg_we = 0;
        chk("t3_cnt_after6", cnt0, 3'd4);
        chk("t3_ovf", ovf0, 1'b0);
        chk("t4_cnt_after6", cnt1, 3'd4);
        chk("t4_ovf", ovf1, 1'b1);
        chk("t4_state", st1, 2'd2);
        stop = 1; tick(); stop = 0;
        chk("t4_done", st1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rd[%0d]", i), dat0,
                mk(stamp[i+1], 32'h200 + 32'(4*(i+1)),
                   5'(i+1), 32'(i+1)));
            chk($sformatf("t4_rd[%0d]", i), dat1,
                mk(stamp[i+3], 32'h200 + 32'(4*(i+3)),
                   5'(i+3), 32'(i+3)));
            rd_ready = 1; tick(); rd_ready = 0;
        end
        chk("t3_empty", vld0, 1'b0);
        chk("t4_empty", vld1, 1'b0);
        chk("t4_ovf_sticky", ovf1, 1'b1);

        // Test 5: backpressure, then arm during readout
        arm = 1; tick(); arm = 0;
        chk("t5_ovf_cleared", ovf1, 1'b0);
        reg_we = 1; reg_waddr = 5'd5; reg_wdata = 32'h55;
        pc = 32'h300; sa = tb_cyc;
        tick();
        reg_waddr = 5'd6; reg_wdata = 32'h66; pc = 32'h304;
        stop = 1;
        tick();
        reg_we = 0; stop = 0;
        chk("t5_stop_write", cnt0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            rd_ready = 0; tick();
            chk($sformatf("t5_hold_vld[%0d]", i), vld0, 1'b1);
            chk($sformatf("t5_hold_dat[%0d]", i), dat0,
                mk(sa, 32'h300, 5'd5, 32'h55));
        end
        arm = 1; rd_ready = 1; tick(); arm = 0; rd_ready = 0;
        chk("t5_arm_cnt", cnt0, 3'd0);
        chk("t5_arm_vld", vld0, 1'b0);
        chk("t5_arm_st", st0, 2'd2);

        // Test 6: reset mid-capture
        reg_we = 1; reg_waddr = 5'd7; reg_wdata = 32'h77;
        tick();
        reg_wdata = 32'h78;
        tick();
        reg_we = 0;
        chk("t6_cnt2", cnt0, 3'd2);
        reset = 1; tick(); reset = 0;
        chk("t6_st", st0, 2'd0);
        chk("t6_cnt", cnt0, 3'd0);
        chk("t6_ovf", ovf1, 1'b0);
        chk("t6_vld", vld0, 1'b0);
        chk("t6_dat", dat0, '0);

        // stop in IDLE ignored; stop in ARMED -> DONE, empty
        stop = 1; tick(); stop = 0;
        chk("idle_stop", st0, 2'd0);
        trig_en = 1; trig_pc = 32'hFFF0; pc = 32'h0;
        arm = 1; tick(); arm = 0;
        chk("armed_st", st0, 2'd1);
        reg_we = 1; reg_waddr = 5'd1; stop = 1;
        tick();
        stop = 0; reg_we = 0;
        chk("armed_stop_st", st0, 2'd3);
        chk("armed_stop_cnt", cnt0, 3'd0);
        chk("armed_stop_vld", vld0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
